// File: rtl/pool1_ctrl_pkg.sv
// Shared LeNet constants and the FSM state encoding for the pool1 controller.
// No logic; types and localparams only.
// Imported by pool1_ctrl and pool1_addr_gen.
package pool1_ctrl_pkg;

  localparam int IN_W   = 28;              // f2 map width/height
  localparam int OUT_W  = 14;              // f3 map width/height
  localparam int F2_AW  = 10;              // f2 buffer address width
  localparam int F3_AW  = 8;               // f3 buffer address width
  localparam int WIN_N  = 196;             // pooling windows per map set
  localparam int WIN_EL = 4;               // elements per 2x2 window
  localparam int RD_N   = WIN_N * WIN_EL;  // f2 reads per run (784)

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pool1_addr_gen.sv
// Window/element counters and f2/f3 address arithmetic for 2x2 max-pool scan.
// Outputs are combinational from the counters; counters step once per i_adv.
// No backpressure: the caller advances every cycle it issues a read.
module pool1_addr_gen
  import pool1_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_adv,
  output logic [F2_AW-1:0] o_raddr,
  output logic [F3_AW-1:0] o_win,
  output logic             o_el0,
  output logic             o_el3,
  output logic             o_last
);

  logic [3:0] r_row;   // window row r, 0..13
  logic [3:0] r_col;   // window column c, 0..13
  logic [1:0] r_el;    // element within window: {dy, dx}

  logic             w_col_end;
  logic             w_row_end;
  logic [F2_AW-1:0] w_f2_row;
  logic [F2_AW-1:0] w_f2_col;

  assign w_col_end = (r_col == 4'(OUT_W - 1));
  assign w_row_end = (r_row == 4'(OUT_W - 1));

  // Element order within a window: (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1)
  assign w_f2_row = F2_AW'({r_row, 1'b0}) + F2_AW'(r_el[1]);
  assign w_f2_col = F2_AW'({r_col, 1'b0}) + F2_AW'(r_el[0]);
  assign o_raddr  = w_f2_row * F2_AW'(IN_W) + w_f2_col;
  assign o_win    = F3_AW'(r_row) * F3_AW'(OUT_W) + F3_AW'(r_col);
  assign o_el0    = (r_el == 2'd0);
  assign o_el3    = (r_el == 2'd3);
  assign o_last   = o_el3 && w_col_end && w_row_end;

  // Row-major window scan; element counter is innermost, column wraps into row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
      r_el  <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
      r_el  <= '0;
    end else if (i_adv) begin
      r_el <= r_el + 2'd1;
      if (r_el == 2'd3) begin
        if (w_col_end) begin
          r_col <= '0;
          r_row <= w_row_end ? 4'd0 : r_row + 4'd1;
        end else begin
          r_col <= r_col + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/pool1_ctrl.sv
// Sequences one 28x28 -> 14x14 2x2 pooling pass: f2 reads, pool clear, f3 writes.
// 788 cycles start-to-IDLE; one f2 read per cycle, f3 write 2 cycles after element 3.
// No backpressure: start is only accepted in IDLE and the run never stalls.
module pool1_ctrl
  import pool1_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [F2_AW-1:0] f2_raddr,
  output logic             f2_ren,
  output logic             pool1_clr,
  output logic [F3_AW-1:0] f3_waddr,
  output logic             f3_wen
);

  state_t r_state;
  state_t w_nxt;

  logic             w_run;
  logic [F2_AW-1:0] w_raddr;
  logic [F3_AW-1:0] w_win;
  logic             w_el0;
  logic             w_el3;
  logic             w_last;

  logic             r_busy;
  logic             r_done;
  logic [F2_AW-1:0] r_f2_raddr;
  logic             r_f2_ren;
  logic             r_pool1_clr;
  logic [F3_AW-1:0] r_f3_waddr;
  logic             r_f3_wen;

  // Delay lines: element 0 flag (clear lands with its read data),
  // element 3 flag plus window index (write lands after the pool unit's register)
  logic             r_e0_d1;
  logic             r_e3_d1;
  logic             r_e3_d2;
  logic [F3_AW-1:0] r_win_d1;
  logic [F3_AW-1:0] r_win_d2;

  assign w_run = (r_state == RUN);

  pool1_addr_gen u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (r_state == IDLE),
    .i_adv   (w_run),
    .o_raddr (w_raddr),
    .o_win   (w_win),
    .o_el0   (w_el0),
    .o_el3   (w_el3),
    .o_last  (w_last)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  // Next-state logic; DRAIN ends once the last window's write is on the bus
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_nxt = RUN;
      RUN:     if (w_last) w_nxt = DRAIN;
      DRAIN:   if (r_f3_wen && (r_f3_waddr == F3_AW'(WIN_N - 1))) w_nxt = DONE;
      DONE:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Registered outputs and delay lines; addresses forced to 0 when not enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_f2_ren    <= 1'b0;
      r_f2_raddr  <= '0;
      r_pool1_clr <= 1'b0;
      r_f3_wen    <= 1'b0;
      r_f3_waddr  <= '0;
      r_e0_d1     <= 1'b0;
      r_e3_d1     <= 1'b0;
      r_e3_d2     <= 1'b0;
      r_win_d1    <= '0;
      r_win_d2    <= '0;
    end else begin
      r_busy      <= (w_nxt == RUN) || (w_nxt == DRAIN);
      r_done      <= (w_nxt == DONE);
      r_f2_ren    <= w_run;
      r_f2_raddr  <= w_run ? w_raddr : '0;
      r_e0_d1     <= w_run && w_el0;
      r_pool1_clr <= r_e0_d1;
      r_e3_d1     <= w_run && w_el3;
      r_win_d1    <= (w_run && w_el3) ? w_win : '0;
      r_e3_d2     <= r_e3_d1;
      r_win_d2    <= r_win_d1;
      r_f3_wen    <= r_e3_d2;
      r_f3_waddr  <= r_e3_d2 ? r_win_d2 : '0;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign f2_ren    = r_f2_ren;
  assign f2_raddr  = r_f2_raddr;
  assign pool1_clr = r_pool1_clr;
  assign f3_wen    = r_f3_wen;
  assign f3_waddr  = r_f3_waddr;

endmodule

// File: tb/tb_pool1_ctrl.sv
// Directed bench for pool1_ctrl: reset, full runs, ignored starts, mid-run reset.
// Cycle c is the interval after the c-th rising edge counted from the start edge.
// Outputs sampled 1 time unit after each rising edge.
module tb_pool1_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic [9:0] f2_raddr;
  logic       f2_ren;
  logic       pool1_clr;
  logic [7:0] f3_waddr;
  logic       f3_wen;

  int total = 0;
  int bad   = 0;

  int seq8[8] = '{0, 1, 28, 29, 2, 3, 30, 31};

  pool1_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .f2_raddr  (f2_raddr),
    .f2_ren    (f2_ren),
    .pool1_clr (pool1_clr),
    .f3_waddr  (f3_waddr),
    .f3_wen    (f3_wen)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [22:0] obs();
    return {busy, done, f2_ren, f2_raddr, pool1_clr, f3_wen, f3_waddr};
  endfunction

  // f2 address of the k-th read of a run, straight from the window definition
  function automatic int rd_addr(input int k);
    int w, e, r, c;
    w = k / 4;
    e = k % 4;
    r = w / 14;
    c = w % 14;
    return (2 * r + e / 2) * 28 + 2 * c + (e % 2);
  endfunction

  // Expected output vector in cycle c of a run (c=0 is the start edge)
  function automatic logic [22:0] expv(input int c);
    logic       b, d, ren, clr, wen;
    logic [9:0] ra;
    logic [7:0] wa;
    b   = (c >= 0) && (c <= 786);
    d   = (c == 787);
    ren = (c >= 1) && (c <= 784);
    ra  = ren ? 10'(rd_addr(c - 1)) : 10'd0;
    clr = (c >= 2) && (c <= 782) && ((c - 2) % 4 == 0);
    wen = (c >= 6) && (c <= 786) && ((c - 6) % 4 == 0);
    wa  = wen ? 8'((c - 6) / 4) : 8'd0;
    return {b, d, ren, ra, clr, wen, wa};
  endfunction

  task automatic chk(input string tag, input int c, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check one run cycle: full vector plus hand-written anchor points
  task automatic check_cycle(input int c);
    chk("vec", c, 32'(obs()), 32'(expv(c)));
    if (c >= 1 && c <= 8) chk("first8_raddr", c, 32'(f2_raddr), 32'(seq8[c-1]));
    case (c)
      2, 6:    chk("clr", c, 32'(pool1_clr), 32'd1);
      53:      chk("w13_e0", c, 32'(f2_raddr), 32'd26);
      54:      chk("w13_e1", c, 32'(f2_raddr), 32'd27);
      55:      chk("w13_e2", c, 32'(f2_raddr), 32'd54);
      56:      chk("w13_e3", c, 32'(f2_raddr), 32'd55);
      57:      chk("w14_e0", c, 32'(f2_raddr), 32'd56);
      58:      chk("w14_e1_waddr13", c, 32'({f2_raddr, f3_wen, f3_waddr}), 32'({10'd57, 1'b1, 8'd13}));
      59:      chk("w14_e2", c, 32'(f2_raddr), 32'd84);
      60:      chk("w14_e3", c, 32'(f2_raddr), 32'd85);
      62:      chk("waddr14", c, 32'({f3_wen, f3_waddr}), 32'({1'b1, 8'd14}));
      784:     chk("last_raddr", c, 32'({f2_ren, f2_raddr}), 32'({1'b1, 10'd783}));
      786:     chk("last_waddr", c, 32'({f3_wen, f3_waddr}), 32'({1'b1, 8'd195}));
      787:     chk("done", c, 32'({busy, done}), 32'({1'b0, 1'b1}));
      default: ;
    endcase
  endtask

  // Expects start already high before the start edge; runs cycles 0..last_c.
  // ign_a/ign_b: cycles in which a stray start is held; chain: start in cycle 788.
  task automatic run_cycles(input int last_c, input int ign_a, input int ign_b, input bit chain);
    int n_ren, n_wen, n_done;
    n_ren  = 0;
    n_wen  = 0;
    n_done = 0;
    tick();
    start = 1'b0;
    check_cycle(0);
    for (int c = 1; c <= last_c; c++) begin
      tick();
      start = (c == ign_a) || (c == ign_b) || (chain && c == 788);
      check_cycle(c);
      n_ren  += int'(f2_ren);
      n_wen  += int'(f3_wen);
      n_done += int'(done);
    end
    if (last_c >= 788) begin
      chk("ren_count", last_c, 32'(n_ren), 32'd784);
      chk("wen_count", last_c, 32'(n_wen), 32'd196);
      chk("done_count", last_c, 32'(n_done), 32'd1);
    end
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("reset_async", -1, 32'(obs()), 32'd0);
    tick();
    chk("reset_held", -1, 32'(obs()), 32'd0);
    start = 1'b1;
    tick();
    chk("reset_start_ignored", -1, 32'(obs()), 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle", -1, 32'(obs()), 32'd0);
    end

    // Run A, chained back-to-back into run B (start held in A's cycle 788)
    start = 1'b1;
    run_cycles(788, -1, -1, 1'b1);
    // Run B with stray starts in cycles 5 and 300
    run_cycles(790, 5, 300, 1'b0);

    // Run C interrupted by reset in cycle 400
    start = 1'b1;
    run_cycles(399, -1, -1, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    chk("midrun_rst_now", 400, 32'(obs()), 32'd0);
    tick();
    chk("midrun_rst_c401", 401, 32'(obs()), 32'd0);
    tick();
    chk("midrun_rst_c402", 402, 32'(obs()), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      chk("post_rst_quiet", 403 + i, 32'(obs()), 32'd0);
    end

    // Run D after the abandoned run
    start = 1'b1;
    run_cycles(790, -1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pool1_ctrl.md
POOL1_CTRL -- requirements
Module: pool1_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: one-cycle request to pool one 28x28 map set into 14x14.
REQ-004 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-005 SHALL have port done, output, 1 bit: one-cycle pulse after the last f3 write.
REQ-006 SHALL have port f2_raddr, output, 10 bits: f2 buffer read address, row*28+col.
REQ-007 SHALL have port f2_ren, output, 1 bit: f2 read enable; data is returned on f2_rdata one cycle later.
REQ-008 SHALL have port pool1_clr, output, 1 bit: drives the pool execute unit; marks f2_rdata as the first element of a window.
REQ-009 SHALL have port f3_waddr, output, 8 bits: f3 buffer write address, r*14+c.
REQ-010 SHALL have port f3_wen, output, 1 bit: f3 write enable; the pooled result is valid on f3_wdata in the same cycle.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-012 SHALL move IDLE->RUN on the clock edge where start=1; start in any other state SHALL be ignored.
REQ-013 SHALL, in RUN, issue exactly one f2 read per cycle (f2_ren=1), with no gaps, for 784 consecutive cycles.
REQ-014 SHALL scan windows row-major: r=0..13 outer, c=0..13 inner.
REQ-015 SHALL read the elements of window (r,c) in this order: (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1).
REQ-016 SHALL assert pool1_clr exactly in the cycle after the read of element 0 of each window; it is low in all other cycles.
REQ-017 SHALL assert f3_wen two cycles after the read of element 3 of a window, with f3_waddr=r*14+c of that window.
REQ-018 SHALL move RUN->DRAIN after the 784th read, and DRAIN->DONE once the final f3_wen (window 195) has been issued.
REQ-019 SHALL assert done for one cycle in DONE, then return to IDLE; busy SHALL be low in DONE.
REQ-020 SHALL give a total latency of 788 cycles: start edge at cycle 0, first f2_ren in cycle 1, last f2_ren in cycle 784, last f3_wen in cycle 786, done in cycle 787, IDLE in cycle 788.
REQ-021 SHALL issue exactly 196 f3 writes per run, each address exactly once, in ascending order 0..195.
REQ-022 SHALL produce no f2_raddr above 783 and no f3_waddr above 195; the column counter wraps 13->0 and increments the row counter.
REQ-023 SHALL hold f2_raddr and f3_waddr at 0 while their enables are low.
REQ-024 SHALL allow back-to-back runs: a start in the cycle after done (IDLE) is accepted.

Reset
REQ-025 SHALL, while rst=1, force the state to IDLE and all outputs to 0: busy, done, f2_ren, f2_raddr, pool1_clr, f3_wen, f3_waddr.
REQ-026 SHALL, when rst is asserted mid-run, abandon the run immediately with no further f3_wen or done, and SHALL accept a new start after rst deasserts.
REQ-027 SHALL clear all counters and pipeline delay registers on reset.

Structure
REQ-028 SHALL take from the shared LeNet package: IN_W=28, OUT_W=14, F2_AW=10, F3_AW=8, WIN_N=196, and the FSM state encoding.
REQ-029 SHALL place the window/element counters and address arithmetic in one sub-module, pool1_addr_gen; the FSM and the 1- and 2-cycle delay lines stay in pool1_ctrl.
REQ-030 SHALL register all outputs, with no combinational path from start to any output.

Verification
REQ-031 Reset then single start -> first f2_raddr sequence 0,1,28,29,2,3,30,31; pool1_clr in cycles 2 and 6; f3_wen with f3_waddr=0 in cycle 6.
REQ-032 Full run -> 784 f2_ren, 196 f3_wen at addresses 0..195; last f2_raddr=783 in cycle 784; done in cycle 787.
REQ-033 Row wrap -> window 13 reads 26,27,54,55; window 14 reads 56,57,84,85; f3_waddr 13 then 14.
REQ-034 start pulsed in cycles 5 and 300 of a run -> both ignored; the run is unchanged, with a single done in cycle 787.
REQ-035 rst=1 in cycle 400 for 2 cycles -> all outputs 0 immediately; no done; new start accepted; full correct run follows.
REQ-036 start in the cycle after done -> second run starts with f2_raddr=0 in the next cycle, identical sequence.
